// File: rtl/syndrome_collector.sv
// -----------------------------------------------------------------------------
// syndrome_collector
//
// Captures one codeword's worth of syndromes (NUM_SYN bytes, presented as a
// single parallel word on a one-cycle syn_valid_in pulse), buffers up to two
// codewords in a ping-pong pair of entries, and hands them in arrival order to
// the key-equation solver.
//
// Each entry stores the syndrome word plus a zero flag (all syndromes == 0),
// which is presented as error_free alongside the head entry.
//
// Handshake on the output side: the head entry is transferred on any cycle
// where syn_valid_out && syn_ready_in. syn_valid_out never drops without a
// transfer, and syn_out/error_free hold steady while stalled. syn_ready_in is
// ignored while syn_valid_out is low.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   syn_in          NUM_SYN*8 syndrome bytes, S0 in bits [7:0]
//   syn_valid_in    one-cycle pulse marking a complete syndrome word
//   syn_out         head-entry syndromes (registered, same packing as syn_in)
//   error_free      head entry has all syndromes zero
//   syn_valid_out   head entry available
//   syn_ready_in    solver accepts the head entry
//   overflow        sticky: a codeword was dropped on a full buffer
//   cw_cnt          accepted codewords (wraps)
//   err_cw_cnt      accepted codewords with a non-zero syndrome (wraps)
// -----------------------------------------------------------------------------
module syndrome_collector #(
  parameter int NUM_SYN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SYN*8-1:0]   syn_in,
  input  logic                   syn_valid_in,
  output logic [NUM_SYN*8-1:0]   syn_out,
  output logic                   error_free,
  output logic                   syn_valid_out,
  input  logic                   syn_ready_in,
  output logic                   overflow,
  output logic [CNT_W-1:0]       cw_cnt,
  output logic [CNT_W-1:0]       err_cw_cnt
);

  localparam int SW = NUM_SYN * 8;

  logic [SW-1:0] mem_data [0:1];
  logic          mem_zf   [0:1];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ;

  logic zf_in;
  logic pop;
  logic push;

  // Zero flag is derived from the incoming word so it is stored with the entry.
  assign zf_in = ~(|syn_in);

  assign pop  = (occ != 2'd0) && syn_ready_in;
  // A full buffer still accepts when the head leaves in the same cycle; the
  // slot being written is then the one being vacated (wr_ptr == rd_ptr).
  assign push = syn_valid_in && ((occ != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_zf[0]   <= 1'b0;
      mem_zf[1]   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      overflow    <= 1'b0;
      cw_cnt      <= '0;
      err_cw_cnt  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= syn_in;
        mem_zf[wr_ptr]   <= zf_in;
        wr_ptr           <= ~wr_ptr;
        cw_cnt           <= cw_cnt + CNT_W'(1);
        if (!zf_in) begin
          err_cw_cnt <= err_cw_cnt + CNT_W'(1);
        end
      end else if (syn_valid_in) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Outputs come straight from stored entries, never from syn_in.
  assign syn_out       = mem_data[rd_ptr];
  assign error_free    = mem_zf[rd_ptr];
  assign syn_valid_out = (occ != 2'd0);

endmodule

// File: tb/tb_syndrome_collector.sv
// -----------------------------------------------------------------------------
// tb_syndrome_collector
//
// Drives directed scenarios followed by randomized traffic into
// syndrome_collector and compares every output, every cycle, against a
// two-deep FIFO reference model built on a queue. Counters are instantiated
// narrow (CNT_W=4) so wrap-around is exercised quickly.
// -----------------------------------------------------------------------------
module tb_syndrome_collector;

  localparam int NUM_SYN = 16;
  localparam int CNT_W   = 4;
  localparam int SW      = NUM_SYN * 8;
  localparam int DEPTH   = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0]    syn_in = '0;
  logic             syn_valid_in = 1'b0;
  logic [SW-1:0]    syn_out;
  logic             error_free;
  logic             syn_valid_out;
  logic             syn_ready_in = 1'b0;
  logic             overflow;
  logic [CNT_W-1:0] cw_cnt;
  logic [CNT_W-1:0] err_cw_cnt;

  syndrome_collector #(.NUM_SYN(NUM_SYN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .syn_in        (syn_in),
    .syn_valid_in  (syn_valid_in),
    .syn_out       (syn_out),
    .error_free    (error_free),
    .syn_valid_out (syn_valid_out),
    .syn_ready_in  (syn_ready_in),
    .overflow      (overflow),
    .cw_cnt        (cw_cnt),
    .err_cw_cnt    (err_cw_cnt)
  );

  // ---------------------------------------------------------------- scoreboard
  // Each expected entry is {zero_flag, syndrome word}, oldest at the front.
  logic [SW:0] exp_q[$];
  int          m_cw;
  int          m_err;
  logic        m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [SW-1:0] got,
                          input logic [SW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cw  = 0;
    m_err = 0;
    m_ovf = 1'b0;
  endtask

  // Compare all DUT outputs with the model's current view.
  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (exp_q.size() != 0);
    check_eq("valid", SW'(syn_valid_out), SW'(exp_valid));
    if (exp_valid) begin
      check_eq("data", syn_out, exp_q[0][SW-1:0]);
      check_eq("error_free", SW'(error_free), SW'(exp_q[0][SW]));
    end
    check_eq("overflow", SW'(overflow), SW'(m_ovf));
    check_eq("cw_cnt", SW'(cw_cnt), SW'(m_cw % (1 << CNT_W)));
    check_eq("err_cw_cnt", SW'(err_cw_cnt), SW'(m_err % (1 << CNT_W)));
  endtask

  // ---------------------------------------------------------------- driver
  // Called at a negedge: checks the state left by the previous posedge, drives
  // this cycle's inputs, then advances the model across the next posedge.
  task automatic step(input logic v, input logic [SW-1:0] d, input logic r);
    bit do_pop;
    bit do_acc;
    check_outputs();
    syn_valid_in = v;
    syn_in       = d;
    syn_ready_in = r;
    do_pop = (exp_q.size() != 0) && r;
    do_acc = v && ((exp_q.size() < DEPTH) || do_pop);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_acc) begin
      exp_q.push_back({(d == '0), d});
      m_cw++;
      if (d != '0) m_err++;
    end else if (v) begin
      m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r);
  endtask

  function automatic logic [SW-1:0] rand_word();
    logic [SW-1:0] w;
    int mode;
    mode = $urandom_range(0, 3);
    w = '0;
    if (mode == 0) begin
      w = '0;
    end else if (mode == 1) begin
      w[$urandom_range(0, NUM_SYN - 1) * 8 +: 8] = 8'($urandom_range(1, 255));
    end else begin
      for (int k = 0; k < SW / 32; k++) w[k*32 +: 32] = $urandom;
    end
    return w;
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    // Outputs must clear without waiting for a clock edge.
    check_eq("rst_valid", SW'(syn_valid_out), SW'(0));
    check_eq("rst_overflow", SW'(overflow), SW'(0));
    check_eq("rst_cw_cnt", SW'(cw_cnt), SW'(0));
    check_eq("rst_err_cnt", SW'(err_cw_cnt), SW'(0));
    check_eq("rst_syn_out", syn_out, '0);
    check_eq("rst_error_free", SW'(error_free), SW'(0));
    syn_valid_in = 1'b0;
    syn_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    logic [SW-1:0] a, b, c, one;
    model_reset();
    one = '0;
    one[7:0] = 8'h01;

    @(negedge clk);
    do_reset();
    @(negedge clk);

    // Single errored codeword, ready high: one-cycle valid at N+1.
    step(1'b1, one, 1'b1);
    idle(3, 1'b1);

    // All-zero codeword.
    do_reset();
    @(negedge clk);
    step(1'b1, '0, 1'b1);
    idle(3, 1'b1);

    // Stall: third push is dropped, then drain in order.
    a = rand_word(); b = rand_word(); c = rand_word();
    a[0] = 1'b1;
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    step(1'b1, c, 1'b0);
    check_eq("ovf_after_drop", SW'(overflow), SW'(1));
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Full buffer with a pop in the same cycle accepts the new word.
    do_reset();
    @(negedge clk);
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    step(1'b1, c, 1'b1);
    idle(4, 1'b1);
    check_eq("no_ovf_on_pushpop", SW'(overflow), SW'(0));

    // 100 back-to-back codewords at full rate.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 100; i++) step(1'b1, rand_word(), 1'b1);
    idle(3, 1'b1);

    // Reset while full, then first push after release.
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    do_reset();
    @(negedge clk);
    step(1'b1, b, 1'b1);
    idle(2, 1'b1);

    // Counter wrap: 15 accepted pushes reach all-ones, the 16th wraps to 0.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 15; i++) step(1'b1, one, 1'b1);
    idle(1, 1'b1);
    check_eq("cw_all_ones", SW'(cw_cnt), SW'(15));
    step(1'b1, one, 1'b1);
    idle(1, 1'b1);
    check_eq("cw_wrap", SW'(cw_cnt), SW'(0));
    check_eq("err_wrap", SW'(err_cw_cnt), SW'(0));

    // Randomized traffic with random back-pressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        @(negedge clk);
      end
      step(1'($urandom_range(0, 99) < 60), rand_word(),
           1'($urandom_range(0, 99) < 55));
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
